// File: rtl/tlb_assoc.sv
// Fully-associative TLB: single-cycle hits, table-walk fill on miss with
// lowest-free / round-robin victim selection, flush with stale-fill guard.
module tlb_assoc #(
    parameter int ENTRIES   = 8,
    parameter int ADDR_W    = 32,
    parameter int PAGE_BITS = 12
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_en,
    input  logic [ADDR_W-1:0]         in_mva,
    input  logic                      in_flush,
    output logic                      out_valid,
    output logic [ADDR_W-1:0]         out_paddr,
    output logic                      out_fault,
    output logic                      out_busy,
    output logic                      out_walk_req,
    output logic [ADDR_W-1:0]         out_walk_mva,
    input  logic                      in_walk_done,
    input  logic                      in_walk_fault,
    input  logic [ADDR_W-PAGE_BITS-1:0] in_walk_pfn
);

    localparam int VPN_W = ADDR_W - PAGE_BITS;
    localparam int IDX_W = $clog2(ENTRIES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WALK,
        ST_RESP
    } state_t;

    state_t state_q, state_d;

    logic [ENTRIES-1:0] valid_q;
    logic [VPN_W-1:0]   vpn_q [ENTRIES];
    logic [VPN_W-1:0]   pfn_q [ENTRIES];
    logic [IDX_W-1:0]   rr_ptr_q;

    logic [ADDR_W-1:0]  mva_q;
    logic [VPN_W-1:0]   walk_pfn_q;
    logic               walk_fault_q;
    logic               stale_q;

    logic [VPN_W-1:0]   req_vpn;
    logic               hit;
    logic [IDX_W-1:0]   hit_idx;
    logic               have_free;
    logic [IDX_W-1:0]   free_idx;
    logic [IDX_W-1:0]   victim_idx;
    logic               lookup_hit;
    logic               fill_en;

    assign req_vpn = in_mva[ADDR_W-1:PAGE_BITS];

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (valid_q[i] && vpn_q[i] == req_vpn && !hit) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    // Scan downward so the lowest-index free slot is the one that sticks.
    always_comb begin
        have_free = 1'b0;
        free_idx  = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                have_free = 1'b1;
                free_idx  = IDX_W'(i);
            end
        end
    end

    assign victim_idx = have_free ? free_idx : rr_ptr_q;

    // A flush coinciding with a lookup wins, so the lookup is handled as a miss.
    assign lookup_hit = in_en && hit && !in_flush;

    assign fill_en = (state_q == ST_WALK) && in_walk_done && !in_walk_fault
                     && !stale_q && !in_flush && !reset;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (in_en && !lookup_hit) state_d = ST_WALK;
            ST_WALK: if (in_walk_done)         state_d = ST_RESP;
            ST_RESP:                           state_d = ST_IDLE;
            default:                           state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            valid_q      <= '0;
            rr_ptr_q     <= '0;
            mva_q        <= '0;
            walk_pfn_q   <= '0;
            walk_fault_q <= 1'b0;
            stale_q      <= 1'b0;
            out_valid    <= 1'b0;
            out_paddr    <= '0;
            out_fault    <= 1'b0;
        end else begin
            state_q   <= state_d;
            out_valid <= 1'b0;
            out_fault <= 1'b0;

            if (state_q == ST_IDLE && in_en) begin
                if (lookup_hit) begin
                    out_valid <= 1'b1;
                    out_paddr <= {pfn_q[hit_idx], in_mva[PAGE_BITS-1:0]};
                end else begin
                    mva_q   <= in_mva;
                    stale_q <= 1'b0;
                end
            end

            if (state_q == ST_WALK) begin
                if (in_walk_done) begin
                    walk_pfn_q   <= in_walk_pfn;
                    walk_fault_q <= in_walk_fault;
                end
                if (in_flush) stale_q <= 1'b1;
            end

            if (state_q == ST_RESP) begin
                out_valid <= 1'b1;
                out_fault <= walk_fault_q;
                out_paddr <= walk_fault_q ? '0 : {walk_pfn_q, mva_q[PAGE_BITS-1:0]};
            end

            if (fill_en) begin
                valid_q[victim_idx] <= 1'b1;
                if (!have_free) rr_ptr_q <= rr_ptr_q + 1'b1;
            end

            if (in_flush) begin
                valid_q  <= '0;
                rr_ptr_q <= '0;
            end
        end
    end

    // NOTE: tag/frame storage is not reset; valid_q alone qualifies every entry.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            vpn_q[victim_idx] <= mva_q[ADDR_W-1:PAGE_BITS];
            pfn_q[victim_idx] <= in_walk_pfn;
        end
    end

    assign out_busy     = (state_q != ST_IDLE);
    assign out_walk_req = (state_q == ST_WALK);
    assign out_walk_mva = mva_q;

endmodule

// File: tb/tb_tlb_assoc.sv
// Self-checking bench for tlb_assoc: directed scenarios plus randomized traffic
// compared against a slot-level behavioural model of the TLB.
module tb_tlb_assoc;

    localparam int ENTRIES = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_en;
    logic [31:0] in_mva;
    logic        in_flush;
    logic        out_valid;
    logic [31:0] out_paddr;
    logic        out_fault;
    logic        out_busy;
    logic        out_walk_req;
    logic [31:0] out_walk_mva;
    logic        in_walk_done;
    logic        in_walk_fault;
    logic [19:0] in_walk_pfn;

    int tests = 0;
    int fails = 0;

    tlb_assoc #(.ENTRIES(ENTRIES), .ADDR_W(32), .PAGE_BITS(12)) dut (
        .clk(clk), .reset(reset), .in_en(in_en), .in_mva(in_mva), .in_flush(in_flush),
        .out_valid(out_valid), .out_paddr(out_paddr), .out_fault(out_fault),
        .out_busy(out_busy), .out_walk_req(out_walk_req), .out_walk_mva(out_walk_mva),
        .in_walk_done(in_walk_done), .in_walk_fault(in_walk_fault), .in_walk_pfn(in_walk_pfn)
    );

    always #5 clk = ~clk;

    // Reference model: slots with valid/vpn/pfn and a round-robin pointer.
    bit          m_valid [ENTRIES];
    logic [19:0] m_vpn   [ENTRIES];
    logic [19:0] m_pfn   [ENTRIES];
    int          m_ptr;

    function automatic void m_flush();
        for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
        m_ptr = 0;
    endfunction

    function automatic bit m_lookup(input logic [19:0] vpn, output logic [19:0] pfn);
        pfn = '0;
        for (int i = 0; i < ENTRIES; i++)
            if (m_valid[i] && m_vpn[i] == vpn) begin
                pfn = m_pfn[i];
                return 1'b1;
            end
        return 1'b0;
    endfunction

    function automatic void m_fill(input logic [19:0] vpn, input logic [19:0] pfn);
        int slot = -1;
        for (int i = 0; i < ENTRIES; i++)
            if (!m_valid[i] && slot < 0) slot = i;
        if (slot < 0) begin
            slot  = m_ptr;
            m_ptr = (m_ptr + 1) % ENTRIES;
        end
        m_valid[slot] = 1'b1;
        m_vpn[slot]   = vpn;
        m_pfn[slot]   = pfn;
    endfunction

    // One translation request; the model decides whether a hit or a walk is expected.
    task automatic do_req(input string name, input logic [31:0] mva, input logic [19:0] pfn,
                          input bit fault, input int delay, input bit flush_with,
                          input bit flush_mid, input bit busy_poke);
        logic [19:0] mpfn;
        logic [31:0] exp_paddr;
        bit          hit;
        @(negedge clk);
        in_en    = 1'b1;
        in_mva   = mva;
        in_flush = flush_with;
        if (flush_with) m_flush();
        hit = m_lookup(mva[31:12], mpfn);
        @(negedge clk);
        in_en    = 1'b0;
        in_flush = 1'b0;
        if (hit) begin
            exp_paddr = {mpfn, mva[11:0]};
            tests++;
            if (out_valid !== 1'b1 || out_paddr !== exp_paddr || out_fault !== 1'b0 || out_walk_req !== 1'b0) begin
                fails++;
                $display("FAIL %s hit: valid=%b paddr=%h fault=%b walk_req=%b, required valid=1 paddr=%h fault=0 walk_req=0",
                         name, out_valid, out_paddr, out_fault, out_walk_req, exp_paddr);
            end
            return;
        end
        tests++;
        if (out_walk_req !== 1'b1 || out_walk_mva !== mva || out_busy !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL %s walk_start: walk_req=%b walk_mva=%h busy=%b valid=%b, required 1 %h 1 0",
                     name, out_walk_req, out_walk_mva, out_busy, out_valid, mva);
        end
        for (int c = 1; c < delay; c++) begin
            if (c == 1 && flush_mid) begin
                in_flush = 1'b1;
                m_flush();
            end
            if (c == 1 && busy_poke) begin
                in_en  = 1'b1;
                in_mva = mva ^ 32'h5555_5000;
            end
            @(negedge clk);
            in_flush = 1'b0;
            in_en    = 1'b0;
        end
        tests++;
        if (out_walk_req !== 1'b1 || out_walk_mva !== mva) begin
            fails++;
            $display("FAIL %s walk_hold: walk_req=%b walk_mva=%h, required 1 %h",
                     name, out_walk_req, out_walk_mva, mva);
        end
        in_walk_done  = 1'b1;
        in_walk_pfn   = pfn;
        in_walk_fault = fault;
        @(negedge clk);
        in_walk_done  = 1'b0;
        in_walk_fault = 1'b0;
        in_walk_pfn   = '0;
        tests++;
        if (out_walk_req !== 1'b0 || out_valid !== 1'b0 || out_busy !== 1'b1) begin
            fails++;
            $display("FAIL %s resp_cycle: walk_req=%b valid=%b busy=%b, required 0 0 1",
                     name, out_walk_req, out_valid, out_busy);
        end
        @(negedge clk);
        exp_paddr = fault ? 32'h0 : {pfn, mva[11:0]};
        tests++;
        if (out_valid !== 1'b1 || out_paddr !== exp_paddr || out_fault !== fault
            || out_busy !== 1'b0 || out_walk_req !== 1'b0) begin
            fails++;
            $display("FAIL %s miss_resp: valid=%b paddr=%h fault=%b busy=%b walk_req=%b, required 1 %h %b 0 0",
                     name, out_valid, out_paddr, out_fault, out_busy, out_walk_req, exp_paddr, fault);
        end
        if (!fault && !flush_mid) m_fill(mva[31:12], pfn);
    endtask

    task automatic do_flush();
        @(negedge clk);
        in_flush = 1'b1;
        m_flush();
        @(negedge clk);
        in_flush = 1'b0;
    endtask

    task automatic test_reset();
        tests++;
        if (out_valid !== 1'b0 || out_fault !== 1'b0 || out_busy !== 1'b0 || out_walk_req !== 1'b0
            || out_paddr !== 32'h0 || out_walk_mva !== 32'h0) begin
            fails++;
            $display("FAIL reset_values: valid=%b fault=%b busy=%b walk_req=%b paddr=%h walk_mva=%h, required all 0",
                     out_valid, out_fault, out_busy, out_walk_req, out_paddr, out_walk_mva);
        end
    endtask

    task automatic test_cold_miss();
        do_req("cold_miss", 32'h0040_3ABC, 20'h12345, 1'b0, 5, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_hit();
        do_req("hit_latency", 32'h0040_3010, 20'h0, 1'b0, 1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] prev_mva;
        logic [19:0] mpfn;
        bit          hit;
        for (int i = 0; i <= 4; i++) begin
            @(negedge clk);
            if (i > 0) begin
                hit = m_lookup(prev_mva[31:12], mpfn);
                tests++;
                if (!hit || out_valid !== 1'b1 || out_paddr !== {mpfn, prev_mva[11:0]} || out_walk_req !== 1'b0) begin
                    fails++;
                    $display("FAIL back_to_back[%0d]: valid=%b paddr=%h walk_req=%b, required 1 %h 0 (model hit=%b)",
                             i, out_valid, out_paddr, out_walk_req, {mpfn, prev_mva[11:0]}, hit);
                end
            end
            if (i < 4) begin
                prev_mva = {20'h00403, 12'($urandom)};
                in_en    = 1'b1;
                in_mva   = prev_mva;
            end else begin
                in_en = 1'b0;
            end
        end
    endtask

    task automatic test_fault();
        do_req("fault_first",  32'h8000_0000, 20'hABCDE, 1'b1, 3, 1'b0, 1'b0, 1'b0);
        do_req("fault_repeat", 32'h8000_0000, 20'hABCDE, 1'b1, 2, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_flush();
        do_req("flush_prehit", 32'h0040_3200, 20'h0, 1'b0, 1, 1'b0, 1'b0, 1'b0);
        do_flush();
        do_req("flush_remiss", 32'h0040_3200, 20'h22222, 1'b0, 2, 1'b0, 1'b0, 1'b0);
        do_req("flush_with_en", 32'h0040_3300, 20'h33333, 1'b0, 2, 1'b1, 1'b0, 1'b0);
        do_req("flush_mid_walk", 32'h0077_7000, 20'h44444, 1'b0, 3, 1'b0, 1'b1, 1'b0);
        do_req("flush_mid_after", 32'h0077_7444, 20'h55555, 1'b0, 2, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_busy();
        do_req("busy_ignore", 32'h0066_6123, 20'h66666, 1'b0, 4, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        tests++;
        if (out_walk_req !== 1'b0 || out_valid !== 1'b0 || out_busy !== 1'b0) begin
            fails++;
            $display("FAIL busy_no_second_walk: walk_req=%b valid=%b busy=%b, required 0 0 0",
                     out_walk_req, out_valid, out_busy);
        end
    endtask

    task automatic test_replacement();
        do_flush();
        for (int v = 1; v <= 9; v++)
            do_req("repl_fill", {20'(v), 12'h0A0}, 20'(32'h70000 + v), 1'b0, 2, 1'b0, 1'b0, 1'b0);
        do_req("repl_vpn2_hit",   32'h0000_2004, 20'h0, 1'b0, 1, 1'b0, 1'b0, 1'b0);
        do_req("repl_vpn1_miss",  32'h0000_1008, 20'h71111, 1'b0, 2, 1'b0, 1'b0, 1'b0);
        do_req("repl_vpn2_evict", 32'h0000_200C, 20'h72222, 1'b0, 2, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_walk();
        bit seen_valid = 1'b0;
        @(negedge clk);
        in_en  = 1'b1;
        in_mva = 32'h0CAF_E123;
        @(negedge clk);
        in_en = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_flush();
        tests++;
        if (out_walk_req !== 1'b0 || out_busy !== 1'b0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_walk: walk_req=%b busy=%b valid=%b, required 0 0 0",
                     out_walk_req, out_busy, out_valid);
        end
        in_walk_done = 1'b1;
        in_walk_pfn  = 20'h99999;
        @(negedge clk);
        in_walk_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (out_valid !== 1'b0 || out_walk_req !== 1'b0) seen_valid = 1'b1;
            @(negedge clk);
        end
        tests++;
        if (seen_valid !== 1'b0) begin
            fails++;
            $display("FAIL late_walk_done: spurious output seen=%b, required 0", seen_valid);
        end
        do_req("after_reset_miss", 32'h0CAF_E123, 20'h0BEEF, 1'b0, 2, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            logic [31:0] mva;
            int          delay;
            bit          fault, fw, fm, bp;
            mva   = {20'(32'h00100 + $urandom_range(0, 11)), 12'($urandom)};
            delay = $urandom_range(1, 4);
            fault = ($urandom_range(0, 7) == 0);
            fw    = ($urandom_range(0, 19) == 0);
            fm    = (delay >= 2) && ($urandom_range(0, 19) == 0);
            bp    = (delay >= 2) && ($urandom_range(0, 3) == 0);
            do_req("random", mva, 20'($urandom), fault, delay, fw, fm, bp);
        end
    endtask

    initial begin
        reset         = 1'b1;
        in_en         = 1'b0;
        in_mva        = '0;
        in_flush      = 1'b0;
        in_walk_done  = 1'b0;
        in_walk_fault = 1'b0;
        in_walk_pfn   = '0;
        m_flush();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        test_reset();
        test_cold_miss();
        test_hit();
        test_back_to_back();
        test_fault();
        test_flush();
        test_busy();
        test_replacement();
        test_reset_mid_walk();
        test_random();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
